// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants, state type and legality check for the data-memory access controller
//   F3_*             : funct3 access size/sign codes
//   state_t          : controller states IDLE/REQ/DONE
//   MAX_WAIT_DEFAULT : default REQ-cycle budget before timeout
//   access_legal()   : 1 when funct3/alignment/direction form a legal access
package dmem_pkg;

  localparam int MAX_WAIT_DEFAULT = 255;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Unsigned variants exist only for loads; halfwords need even and words
  // need 4-byte aligned addresses.
  function automatic logic access_legal(input logic [2:0] f3,
                                        input logic [1:0] lo,
                                        input logic       is_write);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~lo[0];
      F3_W:    ok = (lo == 2'b00);
      F3_BU:   ok = ~is_write;
      F3_HU:   ok = ~is_write & ~lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store lane replication/byte enables and load extraction/extension
//   i_st_f3, i_st_lo, i_st_write, i_st_wdata : store-side request (current inputs)
//   o_be, o_wdata                             : byte enables and lane-replicated store data
//   i_ld_f3, i_ld_lo, i_ld_word               : latched load size/offset and captured word
//   o_ld_data                                 : aligned, extended load data
module mem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  i_st_f3,
  input  logic [1:0]  i_st_lo,
  input  logic        i_st_write,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [2:0]  i_ld_f3,
  input  logic [1:0]  i_ld_lo,
  input  logic [31:0] i_ld_word,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Replicating the narrow datum onto every lane lets the memory pick it up
  // from whichever lane the byte enables select.
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_st_wdata;
    if (i_st_write) begin
      case (i_st_f3)
        F3_B: begin
          o_be    = 4'b0001 << i_st_lo;
          o_wdata = {4{i_st_wdata[7:0]}};
        end
        F3_H: begin
          o_be    = i_st_lo[1] ? 4'b1100 : 4'b0011;
          o_wdata = {2{i_st_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_byte = i_ld_word[{i_ld_lo, 3'b000} +: 8];
    w_half = i_ld_lo[1] ? i_ld_word[31:16] : i_ld_word[15:0];
    case (i_ld_f3)
      F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_ld_data = {24'd0, w_byte};
      F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_ld_data = {16'd0, w_half};
      default: o_ld_data = i_ld_word;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage load/store controller driving a req/ack data memory
//   clk, reset_n              : clock, async active-low reset
//   mem_read, mem_write       : load/store request (both high = store)
//   funct3, addr, wdata       : access size/sign, byte address, store data
//   rdata                     : extended load data, nonzero only in DONE
//   stall, fault, bus_error   : pipeline freeze, illegal-access pulse, timeout pulse
//   m_req/m_we/m_addr/m_be/m_wdata, m_ack/m_rdata : memory bus
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
)(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic        bus_error,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      r_state, w_next;
  logic [7:0]  r_wait;
  logic [2:0]  r_f3;
  logic [1:0]  r_lo;
  logic [31:0] r_word;
  logic        r_bus_error;
  logic        r_m_req, r_m_we;
  logic [31:0] r_m_addr, r_m_wdata;
  logic [3:0]  r_m_be;

  logic        w_any_req, w_legal, w_accept, w_ack_hit, w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ld_data;

  assign w_any_req = mem_read | mem_write;
  assign w_legal   = access_legal(funct3, addr[1:0], mem_write);

  mem_lane_align u_align (
    .i_st_f3    (funct3),
    .i_st_lo    (addr[1:0]),
    .i_st_write (mem_write),
    .i_st_wdata (wdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .i_ld_f3    (r_f3),
    .i_ld_lo    (r_lo),
    .i_ld_word  (r_word),
    .o_ld_data  (w_ld_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // An ack in the last allowed REQ cycle wins over the timeout.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_ack_hit = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req && w_legal) begin
          w_accept = 1'b1;
          w_next   = REQ;
        end
      end
      REQ: begin
        if (m_ack) begin
          w_ack_hit = 1'b1;
          w_next    = DONE;
        end else if (r_wait == WAIT_LAST) begin
          w_timeout = 1'b1;
          w_next    = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m_req     <= 1'b0;
      r_m_we      <= 1'b0;
      r_m_addr    <= '0;
      r_m_be      <= '0;
      r_m_wdata   <= '0;
      r_f3        <= '0;
      r_lo        <= '0;
      r_wait      <= '0;
      r_word      <= '0;
      r_bus_error <= 1'b0;
    end else begin
      r_m_req     <= (w_next == REQ);
      r_bus_error <= w_timeout;
      if (w_accept) begin
        r_m_we    <= mem_write;
        r_m_addr  <= {addr[31:2], 2'b00};
        r_m_be    <= w_be;
        r_m_wdata <= w_wdata;
        r_f3      <= funct3;
        r_lo      <= addr[1:0];
        r_wait    <= '0;
      end else if (r_state == REQ && !m_ack) begin
        r_wait <= r_wait + 8'd1;
      end
      if (w_ack_hit)      r_word <= m_rdata;
      else if (w_timeout) r_word <= '0;
    end
  end

  assign m_req     = r_m_req;
  assign m_we      = r_m_we;
  assign m_addr    = r_m_addr;
  assign m_be      = r_m_be;
  assign m_wdata   = r_m_wdata;
  assign bus_error = r_bus_error;
  assign rdata     = (r_state == DONE) ? w_ld_data : '0;

  // Gated by reset_n so the combinational outputs also read 0 while in reset.
  assign stall = reset_n & ((r_state == REQ) |
                            ((r_state == IDLE) & w_any_req & w_legal));
  assign fault = reset_n & (r_state == IDLE) & w_any_req & ~w_legal;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - scoreboard bench for dmem_access_ctrl
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [31:0] rdata, m_addr, m_wdata;
  logic        stall, fault, bus_error, m_req, m_we;
  logic [3:0]  m_be;
  logic        m_ack;
  logic        resp_ack = 1'b0, stray_ack = 1'b0;
  logic [31:0] m_rdata = 32'd0;

  assign m_ack = resp_ack | stray_ack;

  dmem_access_ctrl #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
    .fault(fault), .bus_error(bus_error), .m_req(m_req), .m_we(m_we),
    .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { bit we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; bit chk_wdata; } bus_t;
  typedef struct { int waits; logic [31:0] data; } mem_t;
  typedef struct { bit is_fault; bit is_load; logic [31:0] rdata; bit berr; int stalls; } out_t;

  bus_t exp_bus[$];
  mem_t mem_q[$];
  out_t exp_out[$];

  int n_tests = 0, n_fail = 0;
  bit in_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Access size in bytes from funct3; 0 for an undefined code.
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  // Reference model: pushes the expected bus beat, memory response and outcome.
  function automatic bit expect_access(input bit rd, input bit wr, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] wd,
                                       input logic [31:0] md, input int waits);
    int sz, off;
    bit legal;
    bus_t b;
    mem_t m;
    out_t o;
    longint v;
    sz  = size_of(f3);
    off = int'(a[1:0]);
    legal = (sz != 0) && ((off % ((sz == 0) ? 1 : sz)) == 0) && !(wr && f3[2]);
    if (!(rd || wr)) return 1'b0;
    o.is_fault = !legal; o.is_load = 0; o.rdata = 0; o.berr = 0; o.stalls = 0;
    if (legal) begin
      b.we = wr; b.addr = a & ~32'h3; b.chk_wdata = wr;
      b.be = wr ? 4'(((1 << sz) - 1) << off) : 4'hF;
      b.wdata = wd;
      if (wr) for (int k = 0; k < 4; k++) b.wdata[8*k +: 8] = wd[8*(k % sz) +: 8];
      exp_bus.push_back(b);
      m.waits = waits; m.data = md;
      mem_q.push_back(m);
      o.is_load = !wr;
      o.berr    = (waits >= MW);
      o.stalls  = (waits >= MW) ? MW + 1 : waits + 2;
      v = {32'd0, md};
      if (waits >= MW) v = 0;
      v = (v >> (8*off)) & ((64'd1 << (8*sz)) - 1);
      if (!f3[2] && sz < 4 && v >= (64'sd1 << (8*sz - 1))) v = v - (64'sd1 << (8*sz));
      o.rdata = 32'(v);
    end
    exp_out.push_back(o);
    return legal;
  endfunction

  task automatic issue(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] md, input int waits);
    bit legal;
    int guard;
    legal = expect_access(rd, wr, f3, a, wd, md, waits);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    if (in_done) begin @(posedge clk); #1; in_done = 0; end
    @(posedge clk); #1;
    if (legal) begin
      guard = 0;
      while (stall && guard < 300) begin @(posedge clk); #1; guard++; end
      check("stall_bound", guard < 300, 1);
      in_done = 1;
    end
  endtask

  task automatic idle(input int n);
    mem_read = 0; mem_write = 0;
    if (in_done) begin @(posedge clk); #1; in_done = 0; end
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Memory responder: acks after the programmed number of wait cycles.
  bit   busy = 0;
  int   cnt = 0;
  mem_t cur;
  initial forever begin
    @(negedge clk);
    resp_ack = 0;
    if (m_req && reset_n) begin
      if (!busy) begin
        if (mem_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL mem_unexpected: got m_req=1 expected no request");
        end else begin
          cur = mem_q.pop_front(); busy = 1; cnt = 0;
        end
      end
      if (busy) begin
        if (cnt == cur.waits) begin resp_ack = 1; m_rdata = cur.data; busy = 0; end
        else cnt++;
      end
    end else begin
      busy = 0;
    end
  end

  // Monitor: compares every bus beat and every outcome against the scoreboard.
  bit   prev_req = 0;
  int   stall_cnt = 0;
  bus_t held;
  out_t got;
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      prev_req = 0; stall_cnt = 0;
    end else begin
      if (stall) stall_cnt++;
      if (m_req && !prev_req) begin
        if (exp_bus.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL bus_unexpected: got m_req=1 addr=%08h expected no request", m_addr);
        end else begin
          held = exp_bus.pop_front();
          check("bus_we", m_we, held.we);
          check("bus_addr", m_addr, held.addr);
          check("bus_be", m_be, held.be);
          if (held.chk_wdata) check("bus_wdata", m_wdata, held.wdata);
        end
      end else if (m_req) begin
        check("bus_hold", {m_we, m_be, m_addr}, {held.we, held.be, held.addr});
      end
      if (fault) begin
        if (exp_out.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL fault_unexpected: got fault=1 expected no outcome");
        end else begin
          got = exp_out.pop_front();
          check("fault_kind", 1, got.is_fault);
          check("fault_stall", stall, 0);
          check("fault_req", m_req, 0);
        end
      end
      if (prev_req && !m_req) begin
        if (exp_out.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL done_unexpected: got completion expected no outcome");
        end else begin
          got = exp_out.pop_front();
          check("done_kind", 0, got.is_fault);
          if (got.is_load) check("rdata", rdata, got.rdata);
          check("bus_error", bus_error, got.berr);
          check("stall_cycles", stall_cnt, got.stalls);
        end
        stall_cnt = 0;
      end else begin
        check("quiet_outs", {bus_error, rdata}, 0);
      end
      prev_req = m_req;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {rdata, m_addr}, 0);
    check("reset_ctl", {m_wdata, m_be, m_req, m_we, stall, fault, bus_error}, 0);
    reset_n = 1;

    issue(1, 0, F3_W,  32'h100, 0, 32'hDEADBEEF, 0);
    issue(1, 0, F3_B,  32'h103, 0, 32'h80FF0000, 0);
    issue(1, 0, F3_BU, 32'h103, 0, 32'h80FF0000, 1);
    issue(1, 0, F3_H,  32'h102, 0, 32'h80FF0000, 0);
    issue(0, 1, F3_B,  32'h101, 32'h000000A5, 0, 0);
    issue(1, 1, F3_H,  32'h102, 32'h1234BEEF, 0, 2);
    issue(1, 0, F3_W,  32'h102, 0, 0, 0);
    issue(0, 1, 3'b011, 32'h100, 32'h55, 0, 0);
    issue(1, 0, F3_HU, 32'h102, 0, 32'h8001F00D, 3);
    issue(1, 0, F3_W,  32'h104, 0, 32'h12345678, 20);
    idle(1);
    stray_ack = 1; @(posedge clk); #1; stray_ack = 0;
    @(posedge clk); #1;
    check("late_ack_req", m_req, 0);

    void'(expect_access(1, 0, F3_W, 32'h200, 0, 32'h11111111, 10));
    mem_read = 1; mem_write = 0; funct3 = F3_W; addr = 32'h200;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 reset_n = 0; #1;
    check("inflight_rst_outs", {rdata, m_addr}, 0);
    check("inflight_rst_ctl", {m_wdata, m_be, m_req, m_we, stall, fault, bus_error}, 0);
    mem_read = 0;
    exp_out.delete(); exp_bus.delete(); mem_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    in_done = 0;
    issue(1, 0, F3_W, 32'h300, 0, 32'hCAFEF00D, 0);

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 3);
      issue(r[0], r[1], 3'($urandom_range(0, 7)), 32'h1000 + 32'($urandom_range(0, 63)),
            $urandom, $urandom, $urandom_range(0, 5));
    end
    idle(5);
    check("exp_out_empty", exp_out.size(), 0);
    check("exp_bus_empty", exp_bus.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Data-memory access controller: the responder side of the `mem_read`/`mem_write` control signals produced by the main decoder. It sits between the MEM stage and a variable-latency data memory. It turns one load/store per instruction into a single req/ack bus transaction with byte enables, stalls the pipeline until the transaction completes, and returns aligned, sign- or zero-extended load data.

## Interface
- `MAX_WAIT`, 255: REQ cycles without `m_ack` before timeout; range 1..255.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `mem_read` in 1: load request from the control unit.
- `mem_write` in 1: store request from the control unit.
- `funct3` in 3: access size/sign. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr` in 32: byte address from the ALU.
- `wdata` in 32: store data (rs2).
- `rdata` out 32: extended load data; valid in the DONE cycle only, 0 otherwise.
- `stall` out 1: freeze the pipeline.
- `fault` out 1: 1-cycle pulse on misaligned access or illegal `funct3`.
- `bus_error` out 1: 1-cycle pulse on timeout.
- `m_req` out 1: memory request, registered.
- `m_we` out 1: 1 = write.
- `m_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `m_be` out 4: byte enables.
- `m_wdata` out 32: lane-replicated store data.
- `m_ack` in 1: memory completion.
- `m_rdata` in 32: read word; sampled only when `m_ack`=1.

## Operation
- FSM states:
  - IDLE: if `mem_read|mem_write` is asserted and the access is legal, latch `m_we`/`m_addr`/`m_be`/`m_wdata`/`funct3`/`addr[1:0]` and go to REQ.
  - REQ: `m_req`=1. On `m_ack`, capture `m_rdata` and go to DONE. If the wait count reaches `MAX_WAIT`, go to DONE with data 0 and pulse `bus_error` in the DONE cycle.
  - DONE: drive `rdata`, then go to IDLE unconditionally. Request inputs are ignored in DONE.
- `stall` is combinational: 1 in REQ, and 1 in IDLE when a legal request is present. It is 0 in DONE and for faulting requests.
- Both `mem_read` and `mem_write` high: treated as a write.
- Legality:
  - H/HU need `addr[0]`=0.
  - W needs `addr[1:0]`=0.
  - Stores allow only B/H/W.
  - Illegal `funct3` or misalignment: no bus transaction, `fault`=1 in that IDLE cycle, `stall`=0.
- Store lanes:
  - SB: `m_be`=`4'b0001<<addr[1:0]`, byte replicated ×4.
  - SH: `m_be`=0011 or 1100 by `addr[1]`, halfword replicated ×2.
  - SW: `m_be`=1111.
  - Loads: `m_be`=1111.
- Load extraction: select the byte/halfword by the latched `addr[1:0]`. B/H sign-extend; BU/HU zero-extend; W passes through.
- A wait counter (8-bit) clears on entry to REQ and increments each REQ cycle without ack.
- An `m_ack` outside REQ is ignored.

## Timing
- Zero-wait memory (ack in the first REQ cycle): IDLE→REQ→DONE, 3 cycles per access, `stall` high for 2.
- Each extra wait cycle adds one stall cycle.
- Timeout: `m_req` high for exactly `MAX_WAIT` cycles, then DONE.
- `m_req`/`m_we`/`m_addr`/`m_be`/`m_wdata` are registered and stable throughout REQ. `m_req` drops the cycle after ack.
- Reset (async, any state): state=IDLE, counter=0.
  - All outputs 0: `m_req`, `m_we`, `m_addr`, `m_be`, `m_wdata`, `rdata`, `stall`, `fault`, `bus_error`.
  - An in-flight transaction is abandoned without a handshake.
- Back-to-back accesses: the next request is accepted in the IDLE cycle after DONE. There is no bubble beyond DONE→IDLE.

## Structure
- Shared package `dmem_pkg`:
  - `funct3` constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum (IDLE/REQ/DONE).
  - `MAX_WAIT` default.
- Sub-module `mem_lane_align` (combinational): store lane replication plus `m_be` generation, and load extraction/extension. Instantiated once.

## Test plan
- LW `addr`=0x100, ack after 0 waits, `m_rdata`=0xDEADBEEF → `m_req` for 1 cycle, `m_be`=1111, `rdata`=0xDEADBEEF in DONE, `stall` high 2 cycles.
- LB `addr`=0x103, `m_rdata`=0x80FF0000 → `rdata`=0xFFFFFF80. LBU at the same address → 0x00000080. LH at 0x102 → 0xFFFF80FF.
- SB `addr`=0x101, `wdata`=0x000000A5 → `m_we`=1, `m_be`=0010, `m_wdata`=0xA5A5A5A5. SH at 0x102 → `m_be`=1100.
- LW at 0x102 → `fault` pulse, `m_req` never asserts, `stall`=0. `funct3`=011 on a store → `fault`.
- `MAX_WAIT`=4, no ack → `m_req` high 4 cycles, `bus_error` pulse, `rdata`=0. A late ack in IDLE is ignored.
- `reset_n` low during REQ → all outputs 0 immediately. After release, a new LW completes normally.
